fir_response_checker: RTL and testbench

FIR_RESPONSE_CHECKER -- requirements
Module: fir_response_checker

---
 rtl/fir_response_checker.sv | 207 ++++++++++++++++++++
 tb/tb_fir_response_checker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_response_checker.sv
// Run-based checker for a 4-tap FIR under test: rebuilds the expected output
// from the tapped input stream, delays it by LAT and counts mismatches against y.
module fir_response_checker #(
  parameter int unsigned C0    = 1,
  parameter int unsigned C1    = 1,
  parameter int unsigned C2    = 1,
  parameter int unsigned C3    = 1,
  parameter int unsigned SHIFT = 0,
  parameter int unsigned LAT   = 1,
  parameter int unsigned NSAMP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_err_idx,
  output logic [15:0] cmp_count
);

  localparam logic [7:0]  C0_B       = 8'(C0);
  localparam logic [7:0]  C1_B       = 8'(C1);
  localparam logic [7:0]  C2_B       = 8'(C2);
  localparam logic [7:0]  C3_B       = 8'(C3);
  localparam logic [2:0]  FILL_LAST  = 3'(LAT - 1);
  localparam logic [15:0] NSAMP_LAST = 16'(NSAMP - 1);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;
  localparam logic [15:0] IDX_NONE   = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                enter_fill_s;
  logic                active_s;
  logic                mismatch_s;
  logic [2:0]          fill_cnt_r;
  logic [7:0]          hist1_r;
  logic [7:0]          hist2_r;
  logic [7:0]          hist3_r;
  logic [8*LAT-1:0]    pipe_r;
  logic [7:0]          pipe_out_s;
  logic [15:0]         p0_s;
  logic [15:0]         p1_s;
  logic [15:0]         p2_s;
  logic [15:0]         p3_s;
  logic [17:0]         sum_s;
  logic [7:0]          exp_s;
  logic [15:0]         err_next_s;
  logic [15:0]         first_next_s;
  logic [15:0]         cmp_next_s;

  // Next-state decode; start is only honoured from IDLE and DONE.
  always_comb begin
    state_s      = state_r;
    enter_fill_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s      = FILL;
          enter_fill_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (fill_cnt_r == FILL_LAST) begin
          state_s = CHECK;
        end else begin
          state_s = FILL;
        end
      end
      CHECK: begin
        if (cmp_count == NSAMP_LAST) begin
          state_s = DONE;
        end else begin
          state_s = CHECK;
        end
      end
      DONE: begin
        if (start) begin
          state_s      = FILL;
          enter_fill_s = 1'b1;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Expected filter output for the current sample; truncation is deliberate.
  always_comb begin
    active_s   = (state_r == FILL) || (state_r == CHECK);
    p0_s       = {8'h00, C0_B} * {8'h00, x};
    p1_s       = {8'h00, C1_B} * {8'h00, hist1_r};
    p2_s       = {8'h00, C2_B} * {8'h00, hist2_r};
    p3_s       = {8'h00, C3_B} * {8'h00, hist3_r};
    sum_s      = {2'b00, p0_s} + {2'b00, p1_s} + {2'b00, p2_s} + {2'b00, p3_s};
    exp_s      = 8'(sum_s >> SHIFT);
    pipe_out_s = pipe_r[8*LAT-1 -: 8];
    mismatch_s = (state_r == CHECK) && (pipe_out_s != y);
  end

  // Run statistics for the next cycle, cleared on every new run.
  always_comb begin
    err_next_s   = err_count;
    first_next_s = first_err_idx;
    cmp_next_s   = cmp_count;
    if (enter_fill_s) begin
      err_next_s   = 16'h0000;
      first_next_s = IDX_NONE;
      cmp_next_s   = 16'h0000;
    end else if (state_r == CHECK) begin
      cmp_next_s = cmp_count + 16'h0001;
      if (mismatch_s) begin
        if (err_count != CNT_MAX) begin
          err_next_s = err_count + 16'h0001;
        end else begin
          err_next_s = err_count;
        end
        if (err_count == 16'h0000) begin
          first_next_s = cmp_count;
        end else begin
          first_next_s = first_err_idx;
        end
      end else begin
        err_next_s   = err_count;
        first_next_s = first_err_idx;
      end
    end else begin
      cmp_next_s = cmp_count;
    end
  end

  // Control state, fill counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      fill_cnt_r    <= 3'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= 16'h0000;
      first_err_idx <= IDX_NONE;
      cmp_count     <= 16'h0000;
    end else begin
      state_r <= state_s;
      if (enter_fill_s) begin
        fill_cnt_r <= 3'd0;
      end else if (state_r == FILL) begin
        fill_cnt_r <= fill_cnt_r + 3'd1;
      end
      busy          <= (state_s == FILL) || (state_s == CHECK);
      done          <= (state_s == DONE);
      pass          <= (state_s == DONE) && (err_next_s == 16'h0000);
      err_count     <= err_next_s;
      first_err_idx <= first_next_s;
      cmp_count     <= cmp_next_s;
    end
  end

  // Tap history; zeroed at run start so it lines up with a freshly reset filter.
  always_ff @(posedge clk) begin
    if (rst || enter_fill_s) begin
      hist1_r <= 8'h00;
      hist2_r <= 8'h00;
      hist3_r <= 8'h00;
    end else if (active_s) begin
      hist1_r <= x;
      hist2_r <= hist1_r;
      hist3_r <= hist2_r;
    end
  end

  if (LAT == 1) begin : g_lat1
    // Single-stage expected-value delay.
    always_ff @(posedge clk) begin
      if (rst || enter_fill_s) begin
        pipe_r <= 8'h00;
      end else if (active_s) begin
        pipe_r <= exp_s;
      end
    end
  end else begin : g_latn
    // Multi-stage expected-value delay; the oldest value sits in the top byte.
    always_ff @(posedge clk) begin
      if (rst || enter_fill_s) begin
        pipe_r <= {(8*LAT){1'b0}};
      end else if (active_s) begin
        pipe_r <= {pipe_r[8*LAT-9:0], exp_s};
      end
    end
  end

endmodule

// File: tb/tb_fir_response_checker.sv
// Randomised self-checking bench: two checker instances (default and a
// weighted/shifted LAT=3 configuration) fed by an ideal reference filter.
module tb_fir_response_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_drv = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  x_drv = 8'h00;
  logic [7:0]  y_drv = 8'h00;
  logic        start_a, start_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] err_a, first_a, cmp_a, err_b, first_b, cmp_b;

  int checks = 0;
  int failures = 0;
  int xs [0:31];
  bit bad [0:31];

  assign start_a = start_drv & ~sel;
  assign start_b = start_drv & sel;

  always #5 clk = ~clk;

  fir_response_checker dut_a (
    .clk(clk), .rst(rst), .start(start_a), .x(x_drv), .y(y_drv),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_idx(first_a), .cmp_count(cmp_a)
  );

  fir_response_checker #(
    .C0(1), .C1(2), .C2(2), .C3(1), .SHIFT(1), .LAT(3), .NSAMP(12)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .x(x_drv), .y(y_drv),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_idx(first_b), .cmp_count(cmp_b)
  );

  function automatic int lat_of(input bit b);
    return b ? 3 : 1;
  endfunction

  function automatic int ns_of(input bit b);
    return b ? 12 : 8;
  endfunction

  // Ideal filter output for sample index t; samples before the run count as 0.
  function automatic int model_exp(input bit b, input int t);
    int c [4];
    int sh;
    int sum;
    if (b) begin c = '{1, 2, 2, 1}; sh = 1; end
    else   begin c = '{1, 1, 1, 1}; sh = 0; end
    sum = 0;
    for (int k = 0; k < 4; k++) if (t - k >= 0) sum += c[k] * xs[t - k];
    return (sum >> sh) % 256;
  endfunction

  // Drives one run; y comes from the ideal filter, XOR-corrupted where bad[] is set.
  task automatic do_run(input bit b, input int restart_at, input int rst_at,
                        output int busy_bad, output int pass_bad, output bit aborted);
    int lat, n, e;
    logic bsy, dn, ps;
    lat = lat_of(b);
    n = lat + ns_of(b);
    busy_bad = 0; pass_bad = 0; aborted = 1'b0;
    sel = b;
    @(posedge clk); #1;
    start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    for (int t = 0; t < n; t++) begin
      x_drv = xs[t][7:0];
      e = 0;
      if (t >= lat) begin
        e = model_exp(b, t - lat);
        if (bad[t - lat]) e = e ^ 8'h5A;
      end
      y_drv = e[7:0];
      start_drv = (t == restart_at);
      rst = (t == rst_at);
      @(posedge clk); #1;
      start_drv = 1'b0;
      if (t == rst_at) begin
        rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      bsy = b ? busy_b : busy_a;
      dn  = b ? done_b : done_a;
      ps  = b ? pass_b : pass_a;
      if (t < n - 1 && (bsy !== 1'b1 || dn !== 1'b0)) busy_bad++;
      if (dn !== 1'b1 && ps !== 1'b0) pass_bad++;
    end
  endtask

  task automatic get_out(input bit b, output logic d, output logic p,
                         output logic [15:0] e, output logic [15:0] f, output logic [15:0] c);
    d = b ? done_b : done_a;
    p = b ? pass_b : pass_a;
    e = b ? err_b : err_a;
    f = b ? first_b : first_a;
    c = b ? cmp_b : cmp_a;
  endtask

  task automatic clear_bad();
    for (int i = 0; i < 32; i++) bad[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
    checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass_a); end
    checks++; if (err_a !== 16'h0000) begin failures++; $display("FAIL reset_err got=%h exp=0000", err_a); end
    checks++; if (cmp_a !== 16'h0000) begin failures++; $display("FAIL reset_cmp got=%h exp=0000", cmp_a); end
    checks++; if (first_a !== 16'hFFFF) begin failures++; $display("FAIL reset_first got=%h exp=ffff", first_a); end
    checks++; if (first_b !== 16'hFFFF || busy_b !== 1'b0) begin failures++; $display("FAIL reset_b got first=%h busy=%b exp first=ffff busy=0", first_b, busy_b); end
    rst = 1'b0;
  endtask

  // Shared result check for a completed run against the scoreboard expectation.
  task automatic test_scenario(input string name, input bit b, input int restart_at);
    int bb, pb, exp_err, exp_first, ns;
    bit ab;
    logic d, p;
    logic [15:0] e, f, c;
    ns = ns_of(b);
    exp_err = 0; exp_first = 16'hFFFF;
    for (int i = ns - 1; i >= 0; i--) if (bad[i]) begin exp_err++; exp_first = i; end
    do_run(b, restart_at, -1, bb, pb, ab);
    get_out(b, d, p, e, f, c);
    checks++; if (bb != 0) begin failures++; $display("FAIL %s_busy bad_cycles=%0d exp=0", name, bb); end
    checks++; if (pb != 0) begin failures++; $display("FAIL %s_pass_early bad_cycles=%0d exp=0", name, pb); end
    checks++; if (d !== 1'b1) begin failures++; $display("FAIL %s_done got=%b exp=1", name, d); end
    checks++; if (p !== (exp_err == 0)) begin failures++; $display("FAIL %s_pass got=%b exp=%0d", name, p, exp_err == 0); end
    checks++; if (e !== 16'(exp_err)) begin failures++; $display("FAIL %s_err got=%0d exp=%0d", name, e, exp_err); end
    checks++; if (f !== 16'(exp_first)) begin failures++; $display("FAIL %s_first got=%h exp=%h", name, f, 16'(exp_first)); end
    checks++; if (c !== 16'(ns)) begin failures++; $display("FAIL %s_cmp got=%0d exp=%0d", name, c, ns); end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 32; i++) xs[i] = i;
    clear_bad();
    test_scenario("ramp", 1'b0, -1);
  endtask

  task automatic test_done_hold();
    int bad_cycles = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done_a !== 1'b1 || cmp_a !== 16'd8 || first_a !== 16'hFFFF) bad_cycles++;
    end
    checks++; if (bad_cycles != 0) begin failures++; $display("FAIL done_hold bad_cycles=%0d exp=0", bad_cycles); end
  endtask

  task automatic test_single_error();
    for (int i = 0; i < 32; i++) xs[i] = i;
    clear_bad();
    bad[5] = 1'b1;
    test_scenario("err_idx5", 1'b0, -1);
  endtask

  task automatic test_all_wrong();
    for (int i = 0; i < 32; i++) xs[i] = $urandom_range(0, 255);
    for (int i = 0; i < 32; i++) bad[i] = 1'b1;
    test_scenario("all_wrong", 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) xs[i] = $urandom_range(0, 255);
    clear_bad();
    test_scenario("back_to_back", 1'b0, -1);
  endtask

  task automatic test_saturated_input();
    for (int i = 0; i < 32; i++) xs[i] = 255;
    clear_bad();
    test_scenario("x255", 1'b0, -1);
    clear_bad();
    bad[3] = 1'b1;
    test_scenario("x255_err3", 1'b0, -1);
  endtask

  task automatic test_weighted();
    for (int i = 0; i < 32; i++) xs[i] = 10;
    clear_bad();
    test_scenario("weighted_x10", 1'b1, -1);
    clear_bad();
    bad[0] = 1'b1; bad[11] = 1'b1;
    test_scenario("weighted_err", 1'b1, -1);
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < 32; i++) xs[i] = $urandom_range(0, 255);
    clear_bad();
    test_scenario("restart_check", 1'b0, 4);
    clear_bad();
    bad[2] = 1'b1;
    test_scenario("restart_fill", 1'b1, 1);
  endtask

  task automatic test_rst_abort();
    int bb, pb, done_seen;
    bit ab;
    for (int i = 0; i < 32; i++) xs[i] = $urandom_range(0, 255);
    for (int i = 0; i < 32; i++) bad[i] = 1'b1;
    do_run(1'b0, -1, 4, bb, pb, ab);
    checks++; if (ab !== 1'b1) begin failures++; $display("FAIL abort_reached got=%b exp=1", ab); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("FAIL abort_state got busy=%b done=%b exp 0 0", busy_a, done_a); end
    checks++; if (err_a !== 16'h0000 || cmp_a !== 16'h0000 || first_a !== 16'hFFFF) begin failures++; $display("FAIL abort_counters got err=%h cmp=%h first=%h exp 0000 0000 ffff", err_a, cmp_a, first_a); end
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_a !== 1'b0 || busy_a !== 1'b0) done_seen++;
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_no_done cycles=%0d exp=0", done_seen); end
  endtask

  task automatic test_rst_priority();
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; start_drv = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_drv = 1'b0;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_over_start got busy=%b exp=0", busy_a); end
    @(posedge clk); #1;
    checks++; if (busy_a !== 1'b0 || cmp_a !== 16'h0000) begin failures++; $display("FAIL rst_over_start_later got busy=%b cmp=%h exp 0 0000", busy_a, cmp_a); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      bit b;
      b = r[0];
      for (int i = 0; i < 32; i++) xs[i] = $urandom_range(0, 255);
      for (int i = 0; i < 32; i++) bad[i] = (r % 4 == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
      test_scenario(b ? "rand_b" : "rand_a", b, -1);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_done_hold();
    test_single_error();
    test_all_wrong();
    test_back_to_back();
    test_saturated_input();
    test_weighted();
    test_restart_ignored();
    test_rst_abort();
    test_rst_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
